// File: rtl/alu_pkg.sv
// Shared types and op decoding for the execute-stage ALU / multiply-divide unit.
// Op codes 16..23 form the M extension, so op[4] & ~op[3] selects the iterative path.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_e;

    // Per-operation context latched at accept for the final sign fix-up.
    typedef struct packed {
        logic hi;     // return upper half of the product
        logic rem;    // return remainder instead of quotient
        logic neg_q;  // negate product / quotient
        logic neg_r;  // negate remainder
    } mctx_t;

    function automatic logic is_mop(input alu_op_e op);
        return op[4] & ~op[3];
    endfunction

    function automatic logic is_signed_a(input alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic is_signed_b(input alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/alu_basic.sv
// Combinational single-cycle ALU operations; unknown codes fall back to ADD.
module alu_basic
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_e               op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        res_o = a_i + b_i;
        case (op_i)
            ALU_SUB:  res_o = a_i - b_i;
            ALU_AND:  res_o = a_i & b_i;
            ALU_OR:   res_o = a_i | b_i;
            ALU_XOR:  res_o = a_i ^ b_i;
            ALU_SLT:  res_o = {{(DATA_WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: res_o = {{(DATA_WIDTH-1){1'b0}}, a_i < b_i};
            ALU_SLL:  res_o = a_i << shamt;
            ALU_SRL:  res_o = a_i >> shamt;
            ALU_SRA:  res_o = $unsigned($signed(a_i) >>> shamt);
            default:  res_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative RV32M multiply/divide path behind a valid/ready handshake.
// Operands are reduced to magnitudes at accept; the sign is re-applied on the final step.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  alu_op_e               op_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    state_e               state;
    logic [CNT_WIDTH-1:0] cnt;
    mctx_t                ctx;
    logic [2*W-1:0]       acc;   // MUL: {hi, lo/multiplier}; DIV: {remainder, quotient}
    logic [W-1:0]         opb;   // multiplicand or divisor magnitude

    logic [W-1:0] basic_res;

    alu_basic #(.DATA_WIDTH(W)) u_basic (
        .op_i  (op_i),
        .a_i   (op1_i),
        .b_i   (op2_i),
        .res_o (basic_res)
    );

    // Operand magnitudes and context for a new M op.
    logic         a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    mctx_t        ctx_d;

    assign a_neg = is_signed_a(op_i) & op1_i[W-1];
    assign b_neg = is_signed_b(op_i) & op2_i[W-1];
    assign a_mag = a_neg ? -op1_i : op1_i;
    assign b_mag = b_neg ? -op2_i : op2_i;

    always_comb begin
        ctx_d = '0;
        if (op_i[2]) begin
            // Divide by zero keeps the all-ones quotient unsigned-looking.
            ctx_d.neg_q = (a_neg ^ b_neg) & (|op2_i);
            ctx_d.neg_r = a_neg;
            ctx_d.rem   = op_i[1];
        end else begin
            ctx_d.neg_q = a_neg ^ b_neg;
            ctx_d.hi    = |op_i[1:0];
        end
    end

    // One shift-add multiply step.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_nxt;
    assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opb : {W{1'b0}})};
    assign mul_nxt = {mul_sum, acc[W-1:1]};

    // One restoring-division step.
    logic [W:0]     rem_sh, rem_diff;
    logic [2*W-1:0] div_nxt;
    assign rem_sh   = {acc[2*W-1:W], acc[W-1]};
    assign rem_diff = rem_sh - {1'b0, opb};
    assign div_nxt  = rem_diff[W] ? {rem_sh[W-1:0],   acc[W-2:0], 1'b0}
                                  : {rem_diff[W-1:0], acc[W-2:0], 1'b1};

    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s, rem_s, m_res;
    assign prod_s = ctx.neg_q ? -mul_nxt : mul_nxt;
    assign quo_s  = ctx.neg_q ? -div_nxt[W-1:0] : div_nxt[W-1:0];
    assign rem_s  = ctx.neg_r ? -div_nxt[2*W-1:W] : div_nxt[2*W-1:W];

    always_comb begin
        m_res = quo_s;
        if (state == MUL) m_res = ctx.hi ? prod_s[2*W-1:W] : prod_s[W-1:0];
        else if (ctx.rem) m_res = rem_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ctx      <= '0;
            acc      <= '0;
            opb      <= '0;
            result_o <= '0;
            zero_o   <= 1'b1;
            valid_o  <= 1'b0;
            ready_o  <= 1'b1;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        if (is_mop(op_i)) begin
                            state   <= op_i[2] ? DIV : MUL;
                            cnt     <= CNT_WIDTH'(W);
                            ctx     <= ctx_d;
                            acc     <= {{W{1'b0}}, (op_i[2] ? a_mag : b_mag)};
                            opb     <= op_i[2] ? b_mag : a_mag;
                            ready_o <= 1'b0;
                        end else begin
                            result_o <= basic_res;
                            zero_o   <= (basic_res == '0);
                            valid_o  <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= (state == MUL) ? mul_nxt : div_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) begin
                        result_o <= m_res;
                        zero_o   <= (m_res == '0);
                        valid_o  <= 1'b1;
                        ready_o  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = ~ready_o;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed scoreboard bench for alu_mdu at DATA_WIDTH 32 and 16.
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        v32, r32, vo32, z32, b32;
    alu_op_e     op32;
    logic [31:0] a32, bb32, res32;

    logic        v16, r16, vo16, z16, b16;
    alu_op_e     op16;
    logic [15:0] a16, bb16, res16;

    alu_mdu #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .valid_i(v32), .ready_o(r32), .op_i(op32),
        .op1_i(a32), .op2_i(bb32), .result_o(res32), .zero_o(z32),
        .valid_o(vo32), .busy_o(b32)
    );

    alu_mdu #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .valid_i(v16), .ready_o(r16), .op_i(op16),
        .op1_i(a16), .op2_i(bb16), .result_o(res16), .zero_o(z16),
        .valid_o(vo16), .busy_o(b16)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int   acc32[$];
    int   acc16[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Record the edge number of every accepted request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            acc32.delete();
            acc16.delete();
        end else begin
            if (v32 && r32) acc32.push_back(cyc);
            if (v16 && r16) acc16.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (vo32) begin
            exp_t e;
            int   a;
            chk("pending32", 32'(q32.size() > 0), 32'd1);
            if (q32.size() > 0) begin
                e = q32.pop_front();
                a = (acc32.size() > 0) ? acc32.pop_front() : -1000;
                chk("result32", res32, e.res);
                chk("zero32", 32'(z32), 32'(e.res == 32'd0));
                chk("latency32", cyc - a, e.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (vo16) begin
            exp_t e;
            int   a;
            chk("pending16", 32'(q16.size() > 0), 32'd1);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                a = (acc16.size() > 0) ? acc16.pop_front() : -1000;
                chk("result16", 32'(res16), e.res);
                chk("zero16", 32'(z16), 32'(e.res == 32'd0));
                chk("latency16", cyc - a, e.lat);
            end
        end
    end

    task automatic send32(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit push);
        int n = 0;
        while (!r32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait32", 32'(r32), 32'd1);
        op32 = op; a32 = a; bb32 = b; v32 = 1'b1;
        if (push) q32.push_back('{res: exp, lat: lat});
        @(negedge clk);
        v32 = 1'b0;
    endtask

    task automatic send16(input alu_op_e op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input int lat);
        int n = 0;
        while (!r16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait16", 32'(r16), 32'd1);
        op16 = op; a16 = a; bb16 = b; v16 = 1'b1;
        q16.push_back('{res: 32'(exp), lat: lat});
        @(negedge clk);
        v16 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain32", q32.size(), 32'd0);
        chk("drain16", q16.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        rst = 1'b1;
        v32 = 1'b0; op32 = ALU_ADD; a32 = '0; bb32 = '0;
        v16 = 1'b0; op16 = ALU_ADD; a16 = '0; bb16 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_result", res32, 32'd0);
        chk("rst_zero", 32'(z32), 32'd1);
        chk("rst_valid", 32'(vo32), 32'd0);
        chk("rst_ready", 32'(r32), 32'd1);
        chk("rst_busy", 32'(b32), 32'd0);
        chk("rst_result16", 32'(res16), 32'd0);

        // Back-to-back single-cycle ops
        send32(ALU_ADD, 32'd5, 32'd7, 32'd12, 1, 1'b1);
        chk("ready_b2b", 32'(r32), 32'd1);
        send32(ALU_SUB, 32'd7, 32'd7, 32'd0, 1, 1'b1);
        send32(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1'b1);
        send32(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b1);
        send32(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b1);
        send32(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1, 1'b1);
        send32(ALU_SLL, 32'd1, 32'd35, 32'd8, 1, 1'b1);
        send32(ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 1, 1'b1);
        send32(ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 1'b1);
        send32(ALU_OR, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 1, 1'b1);
        send32(alu_op_e'(5'd12), 32'd3, 32'd4, 32'd7, 1, 1'b1);
        drain(20);

        // MUL with an ignored request while busy
        send32(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 1'b1);
        op32 = ALU_ADD; a32 = 32'd9; bb32 = 32'd9; v32 = 1'b1;
        low = 0;
        while (!r32 && low < 100) begin
            @(negedge clk);
            low++;
            v32 = 1'b0;
            if (low == 5) chk("busy_during_mul", 32'(b32), 32'd1);
        end
        chk("ready_low_cycles", low, 32'd32);

        send32(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 33, 1'b1);
        send32(ALU_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        send32(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        send32(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
        send32(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        send32(ALU_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 33, 1'b1);
        send32(ALU_REMU, 32'd100, 32'd0, 32'd100, 33, 1'b1);
        send32(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b1);
        send32(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b1);
        send32(ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33, 1'b1);
        send32(ALU_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33, 1'b1);
        drain(200);

        // Reset in the middle of a DIVU: no result may come out of it
        send32(ALU_DIVU, 32'd1000, 32'd7, 32'd0, 33, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_result", res32, 32'd0);
        chk("midrst_ready", 32'(r32), 32'd1);
        chk("midrst_zero", 32'(z32), 32'd1);
        repeat (40) @(negedge clk);
        send32(ALU_ADD, 32'd1, 32'd1, 32'd2, 1, 1'b1);
        drain(20);

        // 16-bit instance
        send16(ALU_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 17);
        send16(ALU_DIVU, 16'hFFFF, 16'h0010, 16'h0FFF, 17);
        send16(ALU_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 17);
        send16(ALU_SRA, 16'h8000, 16'd4, 16'hF800, 1);
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
